// File: rtl/chart_judge.sv
// One-lane rhythm judge: walks the chart ROM, counts song time in frame ticks and
// grades key presses against note times, accumulating score and combo.
module chart_judge #(
  parameter int ADDR_W      = 8,
  parameter int TIME_W      = 14,
  parameter int NOTE_COUNT  = 113,
  parameter int PERFECT_WIN = 3,
  parameter int GOOD_WIN    = 6
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              frame_tick,
  input  logic              key_press,
  input  logic [15:0]       note_entry,
  output logic [ADDR_W-1:0] addr,
  output logic [TIME_W-1:0] song_time,
  output logic              judge_valid,
  output logic [1:0]        judge_code,
  output logic [9:0]        combo,
  output logic [15:0]       score,
  output logic              done,
  output logic [1:0]        state
);

  // Encoding is visible on the state port: IDLE=0, PLAY=1, HOLD=2, DONE=3.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_HOLD = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [1:0] T_HOLD_START = 2'b01;
  localparam logic [1:0] T_HOLD_END   = 2'b10;
  localparam logic [1:0] J_MISS       = 2'b00;
  localparam logic [1:0] J_GOOD       = 2'b01;
  localparam logic [1:0] J_PERFECT    = 2'b10;
  localparam logic signed [TIME_W:0] GOOD_S = (TIME_W+1)'(GOOD_WIN);
  localparam logic [TIME_W:0]        GOOD_U = (TIME_W+1)'(GOOD_WIN);
  localparam logic [TIME_W:0]        PERF_U = (TIME_W+1)'(PERFECT_WIN);
  localparam logic [TIME_W-1:0]      TIME_MAX = '1;

  state_t                   st;
  logic                     key_q;
  logic [1:0]               ntype;
  logic [TIME_W-1:0]        ntime;
  logic signed [TIME_W:0]   diff;
  logic signed [TIME_W:0]   hold_rem;
  logic [TIME_W:0]          abs_diff;
  logic                     press_edge;
  logic                     at_end;
  logic                     do_judge;
  logic [1:0]               jcode;
  logic                     adv;
  state_t                   nstate;
  logic [1:0]               points;
  logic [16:0]              score_sum;

  assign state      = st;
  assign ntype      = note_entry[15:14];
  assign ntime      = note_entry[TIME_W-1:0];
  assign press_edge = key_press & ~key_q;
  assign at_end     = (addr == ADDR_W'(NOTE_COUNT));
  // Positive diff means the note is already in the past; hold_rem is time left to the hold end.
  assign diff       = $signed({1'b0, song_time}) - $signed({1'b0, ntime});
  assign hold_rem   = $signed({1'b0, ntime}) - $signed({1'b0, song_time});
  assign abs_diff   = diff[TIME_W] ? $unsigned(-diff) : $unsigned(diff);

  always_comb begin
    do_judge = 1'b0;
    jcode    = J_MISS;
    adv      = 1'b0;
    nstate   = st;
    case (st)
      S_PLAY: begin
        if (at_end) begin
          nstate = S_DONE;
        end else if (ntype == T_HOLD_END) begin
          adv = 1'b1;
        end else if (diff > GOOD_S) begin
          do_judge = 1'b1;
          adv      = 1'b1;
        end else if (press_edge && abs_diff <= GOOD_U) begin
          do_judge = 1'b1;
          jcode    = (abs_diff <= PERF_U) ? J_PERFECT : J_GOOD;
          adv      = 1'b1;
          if (ntype == T_HOLD_START) nstate = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ntype != T_HOLD_END) begin
          nstate = S_PLAY;
        end else if (key_press && hold_rem <= 0) begin
          do_judge = 1'b1;
          jcode    = J_PERFECT;
          adv      = 1'b1;
          nstate   = S_PLAY;
        end else if (!key_press) begin
          do_judge = 1'b1;
          jcode    = (hold_rem <= GOOD_S) ? J_GOOD : J_MISS;
          adv      = 1'b1;
          nstate   = S_PLAY;
        end
      end
      default: ;
    endcase
  end

  assign points    = (jcode == J_PERFECT) ? 2'd3 : (jcode == J_GOOD) ? 2'd1 : 2'd0;
  assign score_sum = {1'b0, score} + {15'd0, points};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st          <= S_IDLE;
      key_q       <= 1'b0;
      addr        <= '0;
      song_time   <= '0;
      judge_valid <= 1'b0;
      judge_code  <= J_MISS;
      combo       <= '0;
      score       <= '0;
      done        <= 1'b0;
    end else begin
      key_q       <= key_press;
      judge_valid <= do_judge;
      case (st)
        S_IDLE, S_DONE: begin
          if (start) begin
            st        <= S_PLAY;
            addr      <= '0;
            song_time <= '0;
            combo     <= '0;
            score     <= '0;
            done      <= 1'b0;
          end
        end
        default: begin
          st <= nstate;
          if (nstate == S_DONE) done <= 1'b1;
          if (adv) addr <= addr + 1'b1;
          if (frame_tick && song_time != TIME_MAX) song_time <= song_time + 1'b1;
          if (do_judge) begin
            judge_code <= jcode;
            score      <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            if (jcode == J_MISS) combo <= '0;
            else if (combo != 10'd1023) combo <= combo + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chart_judge.sv
// Bench for chart_judge: directed scenarios plus randomized songs checked against a
// judgment-level reference model driven from a bench-held chart ROM.
module tb_chart_judge;

  localparam int NC      = 4;
  localparam int PERF    = 3;
  localparam int GOOD    = 6;
  localparam int T_MAX   = 16383;
  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_DONE  = 3;

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic        frame_tick;
  logic        key_press;
  logic [15:0] note_entry;
  logic [7:0]  addr;
  logic [13:0] song_time;
  logic        judge_valid;
  logic [1:0]  judge_code;
  logic [9:0]  combo;
  logic [15:0] score;
  logic        done;
  logic [1:0]  state;

  logic [15:0] chart [0:255];
  assign note_entry = chart[addr];

  chart_judge #(.ADDR_W(8), .TIME_W(14), .NOTE_COUNT(NC), .PERFECT_WIN(PERF), .GOOD_WIN(GOOD)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .frame_tick(frame_tick),
    .key_press(key_press), .note_entry(note_entry), .addr(addr), .song_time(song_time),
    .judge_valid(judge_valid), .judge_code(judge_code), .combo(combo), .score(score),
    .done(done), .state(state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  // reference model
  int m_mode, m_addr, m_time, m_combo, m_score, m_code;
  bit m_valid, m_done, m_keyq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_addr = 0; m_time = 0; m_combo = 0; m_score = 0; m_code = 0;
    m_valid = 0; m_done = 0; m_keyq = 0;
    exp_q.delete();
  endtask

  task automatic model_judge(input int code);
    m_valid = 1;
    m_code  = code;
    m_score = m_score + ((code == 2) ? 3 : (code == 1) ? 1 : 0);
    if (m_score > 65535) m_score = 65535;
    if (code == 0) m_combo = 0;
    else if (m_combo < 1023) m_combo++;
    exp_q.push_back(code[1:0]);
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    int e_type, e_t, d, ad, old_mode;
    bit pe;
    logic [15:0] e;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    e        = chart[m_addr];
    e_type   = int'(e[15:14]);
    e_t      = int'(e[13:0]);
    pe       = key_press && !m_keyq;
    old_mode = m_mode;
    m_valid  = 0;
    d        = m_time - e_t;
    ad       = (d < 0) ? -d : d;
    case (m_mode)
      M_IDLE, M_DONE: if (start) begin
        m_mode = M_PLAY; m_addr = 0; m_time = 0; m_combo = 0; m_score = 0; m_done = 0;
      end
      M_PLAY: begin
        if (m_addr == NC) begin
          m_mode = M_DONE; m_done = 1;
        end else if (e_type == 2) begin
          m_addr++;
        end else if (d > GOOD) begin
          model_judge(0); m_addr++;
        end else if (pe && ad <= GOOD) begin
          model_judge((ad <= PERF) ? 2 : 1); m_addr++;
          if (e_type == 1) m_mode = M_HOLD;
        end
      end
      default: begin
        if (e_type != 2) begin
          m_mode = M_PLAY;
        end else if (key_press && m_time >= e_t) begin
          model_judge(2); m_addr++; m_mode = M_PLAY;
        end else if (!key_press) begin
          model_judge((e_t - m_time <= GOOD) ? 1 : 0); m_addr++; m_mode = M_PLAY;
        end
      end
    endcase
    if ((old_mode == M_PLAY || old_mode == M_HOLD) && frame_tick && m_time < T_MAX) m_time++;
    m_keyq = key_press;
  endtask

  // scoreboard
  task automatic compare_all();
    chk("addr", 32'(addr), m_addr);
    chk("song_time", 32'(song_time), m_time);
    chk("judge_valid", 32'(judge_valid), 32'(m_valid));
    chk("judge_code", 32'(judge_code), m_code);
    chk("combo", 32'(combo), m_combo);
    chk("score", 32'(score), m_score);
    chk("done", 32'(done), 32'(m_done));
    chk("state", 32'(state), m_mode);
    if (judge_valid) begin
      chk("judge_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("judge_q_code", 32'(judge_code), 32'(exp_q.pop_front()));
    end
  endtask

  // driver tasks
  task automatic cycle();
    model_step();
    @(posedge Clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; start = 1'b0; frame_tick = 1'b0; key_press = 1'b0;
    cycle();
    Reset_n = 1'b1;
    cycle();
  endtask

  task automatic start_song();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until(input int t, input bit kp);
    key_press  = kp;
    frame_tick = 1'b1;
    for (int n = 0; n < 20000 && m_time != t; n++) cycle();
    chk("run_until_time", 32'(song_time), t);
  endtask

  task automatic press_once();
    key_press = 1'b1;
    cycle();
  endtask

  task automatic fill_chart();
    for (int i = 0; i < 256; i++) chart[i] = 16'h3FFF;
  endtask

  task automatic hold_chart();
    fill_chart();
    chart[0] = 16'h4100;
    chart[1] = 16'h8110;
  endtask

  initial begin
    Reset_n = 1'b0; start = 1'b0; frame_tick = 1'b0; key_press = 1'b0;
    model_reset();
    fill_chart();
    #3;
    compare_all();
    chk("reset_state", 32'(state), M_IDLE);

    // Tap PERFECT at 72 against t=71
    chart[0] = 16'h0047;
    do_reset();
    start_song();
    run_until(72, 1'b0);
    press_once();
    chk("tap_perf_valid", 32'(judge_valid), 1);
    chk("tap_perf_code", 32'(judge_code), 2);
    chk("tap_perf_score", 32'(score), 3);
    chk("tap_perf_combo", 32'(combo), 1);
    chk("tap_perf_addr", 32'(addr), 1);

    // Tap GOOD at 76
    do_reset();
    start_song();
    run_until(76, 1'b0);
    press_once();
    chk("tap_good_code", 32'(judge_code), 1);
    chk("tap_good_score", 32'(score), 1);

    // Early press ignored, then MISS once the window has passed
    do_reset();
    start_song();
    run_until(60, 1'b0);
    press_once();
    chk("early_no_valid", 32'(judge_valid), 0);
    chk("early_addr", 32'(addr), 0);
    run_until(78, 1'b0);
    cycle();
    chk("miss_valid", 32'(judge_valid), 1);
    chk("miss_code", 32'(judge_code), 0);
    chk("miss_combo", 32'(combo), 0);
    chk("miss_addr", 32'(addr), 1);

    // Hold: PERFECT start, hold to end
    hold_chart();
    do_reset();
    start_song();
    run_until(256, 1'b0);
    press_once();
    chk("hold_start_state", 32'(state), M_HOLD);
    chk("hold_start_score", 32'(score), 3);
    run_until(272, 1'b1);
    cycle();
    chk("hold_end_code", 32'(judge_code), 2);
    chk("hold_end_addr", 32'(addr), 2);
    chk("hold_end_score", 32'(score), 6);
    chk("hold_end_state", 32'(state), M_PLAY);

    // Hold released early at 260 -> MISS
    do_reset();
    start_song();
    run_until(256, 1'b0);
    press_once();
    run_until(260, 1'b1);
    key_press = 1'b0;
    cycle();
    chk("hold_rel_valid", 32'(judge_valid), 1);
    chk("hold_rel_code", 32'(judge_code), 0);
    chk("hold_rel_combo", 32'(combo), 0);
    chk("hold_rel_addr", 32'(addr), 2);

    // Hold released at 268 -> GOOD
    do_reset();
    start_song();
    run_until(256, 1'b0);
    press_once();
    run_until(268, 1'b1);
    key_press = 1'b0;
    cycle();
    chk("hold_good_code", 32'(judge_code), 1);
    chk("hold_good_score", 32'(score), 4);

    // Hold start never pressed: MISS, then orphan end skipped silently
    do_reset();
    start_song();
    run_until(263, 1'b0);
    cycle();
    chk("hold_miss_code", 32'(judge_code), 0);
    chk("hold_miss_addr", 32'(addr), 1);
    cycle();
    chk("orphan_addr", 32'(addr), 2);
    chk("orphan_no_valid", 32'(judge_valid), 0);
    chk("orphan_score", 32'(score), 0);

    // Full song to DONE, then restart
    fill_chart();
    chart[0] = 16'h000A; chart[1] = 16'h0014; chart[2] = 16'h001E; chart[3] = 16'h0028;
    do_reset();
    start_song();
    for (int i = 0; i < NC; i++) begin
      run_until(10 * (i + 1), 1'b0);
      press_once();
    end
    key_press = 1'b0;
    cycle();
    chk("end_done", 32'(done), 1);
    chk("end_state", 32'(state), M_DONE);
    chk("end_score", 32'(score), 12);
    chk("end_combo", 32'(combo), 4);
    chk("end_addr", 32'(addr), NC);
    for (int i = 0; i < 4; i++) cycle();
    chk("done_time_frozen", 32'(song_time), 42);
    start_song();
    chk("restart_addr", 32'(addr), 0);
    chk("restart_score", 32'(score), 0);
    chk("restart_state", 32'(state), M_PLAY);
    chk("restart_done", 32'(done), 0);

    // Asynchronous reset in the middle of a hold
    hold_chart();
    do_reset();
    start_song();
    run_until(256, 1'b0);
    press_once();
    cycle();
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async_rst_time", 32'(song_time), 0);
    chk("async_rst_state", 32'(state), M_IDLE);
    cycle();
    Reset_n = 1'b1;
    frame_tick = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("idle_ignores_tick", 32'(song_time), 0);

    // Randomized songs
    do_reset();
    for (int s = 0; s < 40; s++) begin
      int t;
      fill_chart();
      t = 0;
      for (int i = 0; i < NC; i++) begin
        logic [13:0] tt;
        logic [1:0]  ty;
        t  = t + $urandom_range(8, 40);
        tt = 14'(t);
        ty = 2'($urandom_range(0, 3));
        chart[i] = {ty, tt};
      end
      start_song();
      for (int n = 0; n < 4000 && m_mode != M_DONE; n++) begin
        frame_tick = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) key_press = ~key_press;
        start = ($urandom_range(0, 40) == 0);
        cycle();
      end
      start = 1'b0;
      chk("rand_song_done", 32'(done), 1);
    end

    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
